down_timer_ctrl: RTL and testbench

DOWN_TIMER_CTRL -- requirements
Module: down_timer_ctrl

---
 rtl/down_timer_pkg.sv | 9 +
 rtl/dcnt_core.sv | 24 ++
 rtl/down_timer_ctrl.sv | 113 +++++++++++
 tb/tb_down_timer_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/down_timer_pkg.sv
// Shared definitions for the down timer: FSM state encoding.
package down_timer_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/dcnt_core.sv
// Down-counter datapath: synchronous load, decrement that saturates at zero.
module dcnt_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] cnt
);

  // Load wins over decrement; a decrement at zero is a no-op, never a wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - WIDTH'(1);
    end
  end

endmodule

// File: rtl/down_timer_ctrl.sv
// Down timer control FSM (IDLE/RUN/PAUSE/DONE) around dcnt_core.
// Define DOWN_TIMER_AUTO_RELOAD_EN to reload the last start value at terminal count.
module down_timer_ctrl
  import down_timer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             tick_i,
  input  logic             pause_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             busy_o,
  output logic             done_o,
  output state_t           state_o
);

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic             load, dec;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q;
  logic             start_acc;

  assign start_acc = start_i && !abort_i && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= '0;
    end else if (start_acc) begin
      reload_q <= load_val_i;
    end
  end
`endif

  dcnt_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .cnt      (cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Abort overrides everything, including the terminal-count done pulse.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    load     = 1'b0;
    load_val = load_val_i;
    dec      = 1'b0;
    if (abort_i) begin
      state_d  = IDLE;
      load     = 1'b1;
      load_val = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_d = RUN;
            load    = 1'b1;
          end
        end
        RUN: begin
          if (pause_i) begin
            state_d = PAUSE;
          end else if (tick_i) begin
            if (cnt != '0) begin
              dec = 1'b1;
            end else begin
              done_d = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
              load     = 1'b1;
              load_val = reload_q;
`else
              state_d  = DONE;
`endif
            end
          end
        end
        PAUSE: begin
          // Resume edge only changes state; the count is untouched.
          if (!pause_i) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_o   = cnt;
    busy_o  = (state_q == RUN) || (state_q == PAUSE);
    done_o  = done_q;
    state_o = state_q;
  end

endmodule

// File: tb/tb_down_timer_ctrl.sv
// Directed self-checking bench for down_timer_ctrl (WIDTH=4).
module tb_down_timer_ctrl;
  import down_timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic [3:0] load_val_i = '0;
  logic       tick_i = 1'b0;
  logic       pause_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [3:0] cnt_o;
  logic       busy_o;
  logic       done_o;
  state_t     state_o;

  int total = 0;
  int bad = 0;
  bit ar;

  down_timer_ctrl #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .load_val_i (load_val_i),
    .tick_i     (tick_i),
    .pause_i    (pause_i),
    .abort_i    (abort_i),
    .cnt_o      (cnt_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    start_i = 1'b0; tick_i = 1'b0; pause_i = 1'b0; abort_i = 1'b1;
    step();
    abort_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++; if (cnt_o !== 4'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", cnt_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done_o); end
    total++; if (state_o !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", state_o, IDLE); end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_count();
    logic [3:0] exp_seq [3];
    exp_seq = '{4'd2, 4'd1, 4'd0};
    load_val_i = 4'd3; start_i = 1'b1; tick_i = 1'b1;
    step();
    start_i = 1'b0;
    total++; if (cnt_o !== 4'd3) begin bad++; $display("FAIL count_load: got %0d want 3", cnt_o); end
    total++; if (state_o !== RUN || busy_o !== 1'b1) begin bad++; $display("FAIL count_run: state %0d busy %b want %0d 1", state_o, busy_o, RUN); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (cnt_o !== exp_seq[i]) begin bad++; $display("FAIL count_seq%0d: got %0d want %0d", i, cnt_o, exp_seq[i]); end
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL count_early_done%0d: got %b want 0", i, done_o); end
    end
    step();
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL count_done: got %b want 1", done_o); end
    total++; if (state_o !== (ar ? RUN : DONE)) begin bad++; $display("FAIL count_state: got %0d want %0d", state_o, ar ? RUN : DONE); end
    total++; if (busy_o !== ar) begin bad++; $display("FAIL count_busy: got %b want %b", busy_o, ar); end
    total++; if (cnt_o !== (ar ? 4'd3 : 4'd0)) begin bad++; $display("FAIL count_term_cnt: got %0d want %0d", cnt_o, ar ? 3 : 0); end
    step();
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL count_done_width: got %b want 0", done_o); end
    total++; if (state_o !== (ar ? RUN : DONE)) begin bad++; $display("FAIL count_hold: got %0d want %0d", state_o, ar ? RUN : DONE); end
    go_idle();
  endtask

  task automatic test_pause();
    logic [3:0] exp_seq [3];
    exp_seq = '{4'd2, 4'd1, 4'd0};
    load_val_i = 4'd5; start_i = 1'b1; tick_i = 1'b1;
    step();
    start_i = 1'b0;
    step(); step();
    total++; if (cnt_o !== 4'd3) begin bad++; $display("FAIL pause_pre: got %0d want 3", cnt_o); end
    pause_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (cnt_o !== 4'd3 || state_o !== PAUSE || busy_o !== 1'b1) begin
        bad++; $display("FAIL pause_hold%0d: cnt %0d state %0d busy %b want 3 %0d 1", i, cnt_o, state_o, busy_o, PAUSE);
      end
    end
    pause_i = 1'b0;
    step();
    total++; if (cnt_o !== 4'd3 || state_o !== RUN) begin bad++; $display("FAIL pause_resume: cnt %0d state %0d want 3 %0d", cnt_o, state_o, RUN); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (cnt_o !== exp_seq[i]) begin bad++; $display("FAIL pause_seq%0d: got %0d want %0d", i, cnt_o, exp_seq[i]); end
    end
    step();
    total++; if (done_o !== 1'b1) begin bad++; $display("FAIL pause_done: got %b want 1", done_o); end
    go_idle();
  endtask

  task automatic test_abort();
    load_val_i = 4'd7; start_i = 1'b1; abort_i = 1'b1;
    step();
    start_i = 1'b0; abort_i = 1'b0;
    total++; if (state_o !== IDLE || cnt_o !== 4'd0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL abort_start: state %0d cnt %0d busy %b want %0d 0 0", state_o, cnt_o, busy_o, IDLE);
    end
    load_val_i = 4'd5; start_i = 1'b1; tick_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0; tick_i = 1'b0;
    total++; if (state_o !== IDLE || cnt_o !== 4'd0) begin bad++; $display("FAIL abort_run: state %0d cnt %0d want %0d 0", state_o, cnt_o, IDLE); end
    load_val_i = 4'd0; start_i = 1'b1;
    step();
    start_i = 1'b0; tick_i = 1'b1; abort_i = 1'b1;
    step();
    abort_i = 1'b0; tick_i = 1'b0;
    total++; if (done_o !== 1'b0 || state_o !== IDLE) begin bad++; $display("FAIL abort_terminal: done %b state %0d want 0 %0d", done_o, state_o, IDLE); end
    step();
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL abort_terminal_late: got %b want 0", done_o); end
  endtask

  task automatic test_no_reload();
    load_val_i = 4'd6; start_i = 1'b1; tick_i = 1'b1;
    step();
    start_i = 1'b0;
    step(); step();
    total++; if (cnt_o !== 4'd4) begin bad++; $display("FAIL noreload_pre: got %0d want 4", cnt_o); end
    load_val_i = 4'd9; start_i = 1'b1;
    step();
    total++; if (cnt_o !== 4'd3) begin bad++; $display("FAIL noreload_run: got %0d want 3", cnt_o); end
    step();
    total++; if (cnt_o !== 4'd2) begin bad++; $display("FAIL noreload_next: got %0d want 2", cnt_o); end
    start_i = 1'b0; pause_i = 1'b1;
    step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    total++; if (cnt_o !== 4'd2 || state_o !== PAUSE) begin bad++; $display("FAIL noreload_pause: cnt %0d state %0d want 2 %0d", cnt_o, state_o, PAUSE); end
    go_idle();
  endtask

  task automatic test_zero_load();
    load_val_i = 4'd0; start_i = 1'b1; tick_i = 1'b0;
    step();
    start_i = 1'b0;
    step();
    total++; if (state_o !== RUN || done_o !== 1'b0) begin bad++; $display("FAIL zero_wait: state %0d done %b want %0d 0", state_o, done_o, RUN); end
    tick_i = 1'b1;
    step();
    tick_i = 1'b0;
    total++; if (done_o !== 1'b1 || state_o !== (ar ? RUN : DONE)) begin
      bad++; $display("FAIL zero_done: done %b state %0d want 1 %0d", done_o, state_o, ar ? RUN : DONE);
    end
    load_val_i = 4'd2; start_i = 1'b1;
    step();
    start_i = 1'b0;
    total++; if (cnt_o !== (ar ? 4'd0 : 4'd2) || state_o !== RUN) begin
      bad++; $display("FAIL zero_restart: cnt %0d state %0d want %0d %0d", cnt_o, state_o, ar ? 0 : 2, RUN);
    end
    go_idle();
  endtask

  task automatic test_async_reset();
    int seen_done;
    load_val_i = 4'd8; start_i = 1'b1; tick_i = 1'b1;
    step();
    start_i = 1'b0;
    step(); step();
    total++; if (cnt_o !== 4'd6) begin bad++; $display("FAIL arst_pre: got %0d want 6", cnt_o); end
    #2 rst = 1'b1;
    #1;
    total++; if (cnt_o !== 4'd0 || busy_o !== 1'b0 || state_o !== IDLE) begin
      bad++; $display("FAIL arst_now: cnt %0d busy %b state %0d want 0 0 %0d", cnt_o, busy_o, state_o, IDLE);
    end
    #1 rst = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done_o !== 1'b0 || cnt_o !== 4'd0) seen_done++;
    end
    total++; if (seen_done !== 0) begin bad++; $display("FAIL arst_after: bad cycles %0d want 0", seen_done); end
    tick_i = 1'b0;
  endtask

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    logic [3:0] exp_cnt [7];
    logic       exp_done [7];
    exp_cnt  = '{4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    load_val_i = 4'd2; start_i = 1'b1; tick_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      start_i = 1'b0;
      total++; if (cnt_o !== exp_cnt[i] || done_o !== exp_done[i] || busy_o !== 1'b1) begin
        bad++; $display("FAIL autoreload%0d: cnt %0d done %b busy %b want %0d %b 1", i, cnt_o, done_o, busy_o, exp_cnt[i], exp_done[i]);
      end
    end
    go_idle();
  endtask
`endif

  initial begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    ar = 1'b1;
`else
    ar = 1'b0;
`endif
    test_reset();
    test_count();
    test_pause();
    test_abort();
    test_no_reload();
    test_zero_load();
    test_async_reset();
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
